mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter RAM_AW, default 17, meaning RAM byte-address width (2^RAM_AW bytes).
REQ-002 SHALL have parameter TX_DEPTH, default 16, meaning TX FIFO entries (power of 2).
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 rdy  input  1  global enable; low freezes all state.
REQ-006 addr_in  input  32  byte address from cache requester.
REQ-007 r_nw_in  input  1  request type: 0 read, 1 write (requester encoding).
REQ-008 wdata_in  input  8  write byte.
REQ-009 rdata_out  output  8  read byte returned to requester.
REQ-010 tx_valid  output  1  TX FIFO head byte available.
REQ-011 tx_data  output  8  TX FIFO head byte.
REQ-012 tx_ready  input  1  sink accepts tx_data this cycle.
REQ-013 rx_valid  input  1  source offers rx_data.
REQ-014 rx_data  input  8  incoming byte.
REQ-015 rx_ready  output  1  RX holding register can accept a byte.
REQ-016 halt  output  1  sticky program-end flag.

Function
REQ-017 Region decode: addr_in[17]==0 -> RAM, index addr_in[RAM_AW-1:0]; addr_in[17]==1 -> IO, register select addr_in[2:0].
REQ-018 Every cycle is a request; no request-valid signal; idle requester drives address 0, read.
REQ-019 RAM write: r_nw_in=1 -> mem[index] <= wdata_in at the edge.
REQ-020 RAM read: rdata_out <= mem[index] at the edge; byte valid exactly one cycle after address presented.
REQ-021 Back-to-back requests at consecutive addresses, one byte per cycle, no stalls.
REQ-022 IO write sel 0: push wdata_in to TX FIFO.
REQ-023 IO write sel 4: halt <= 1; stays 1 until reset.
REQ-024 IO read sel 0: rdata_out <= RX holding byte and clear holding register if full; rdata_out <= 0 if empty.
REQ-025 IO read sel 4: rdata_out <= {6'b0, rx_full, tx_full}.
REQ-026 Other IO selects: writes ignored, reads return 0.
REQ-027 IO reads also have one-cycle latency; IO access never touches RAM.
REQ-028 TX FIFO: head/tail pointers log2(TX_DEPTH) bits wrapping modulo depth; count log2(TX_DEPTH)+1 bits.
REQ-029 tx_valid = count!=0; tx_data = entry at tail; pop when tx_valid && tx_ready.
REQ-030 Push when full with no same-cycle pop: byte dropped, pointers/count unchanged.
REQ-031 Push when full with same-cycle pop: push accepted, count stays TX_DEPTH.
REQ-032 Push and pop otherwise simultaneous: both performed, count unchanged.
REQ-033 tx_full = (count==TX_DEPTH).
REQ-034 RX: rx_ready = ~rst && ~rx_full; capture rx_data, set rx_full when rx_valid && rx_ready.
REQ-035 IO read sel 0 while a new byte is captured same cycle: old byte returned, new byte held, rx_full stays 1.
REQ-036 rdy low: no RAM write, no FIFO push/pop, no RX capture, rdata_out holds, halt holds; rx_ready driven 0.

Reset
REQ-037 rst high: rdata_out=0, TX pointers/count=0, tx_valid=0, rx_full=0, halt=0; rst dominates rdy.
REQ-038 RAM contents not cleared by reset.
REQ-039 Reset mid-transfer: pending TX bytes and held RX byte discarded; first post-reset request decoded normally.

Verification
REQ-040 Write 0xA5 to 0x00010, read 0x00010 next cycle -> rdata_out=0xA5 one cycle after read address.
REQ-041 Write bytes 0x11,0x22,0x33,0x44 at 0x100..0x103, read 0x100..0x103 back-to-back -> 0x11,0x22,0x33,0x44 on consecutive cycles.
REQ-042 tx_ready=0, write 17 bytes 0..16 to 0x30000 -> status read=0x01, then tx_ready=1 drains 0..15 in order, byte 16 absent, tx_valid=0 after.
REQ-043 rx_valid=1 rx_data=0x5A -> rx_ready falls, status read=0x02; read 0x30000 -> 0x5A, next read 0x30000 -> 0x00.
REQ-044 Write 0x30004 -> halt=1 next cycle; rdy=0 during RAM write to 0x20 -> mem[0x20] unchanged; rst -> halt=0, tx_valid=0.

Source files
------------

// File: rtl/mem_responder.sv
// mem_responder: byte RAM plus memory-mapped TX FIFO, RX holding register and halt flag
module mem_responder #(
  parameter int RAM_AW = 17,
  parameter int TX_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic [31:0] addr_in,
  input  logic        r_nw_in,
  input  logic [7:0]  wdata_in,
  output logic [7:0]  rdata_out,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        halt
);
  localparam int PW = $clog2(TX_DEPTH);
  logic [7:0] r_mem [2**RAM_AW];
  logic [7:0] r_tx [TX_DEPTH];
  logic [PW-1:0] r_head, r_tail;
  logic [PW:0] r_cnt;
  logic [7:0] r_rx;
  logic r_rx_full;
  logic [RAM_AW-1:0] w_idx;
  logic [2:0] w_sel;
  logic w_io, w_en, w_ram_wr, w_tx_full, w_pop, w_push, w_rx_rd, w_rx_cap, w_halt_wr, w_unused;
  logic [7:0] w_rdata;
  assign w_unused = ^addr_in;
  assign w_idx = addr_in[RAM_AW-1:0];
  assign w_sel = addr_in[2:0];
  assign w_io = addr_in[17];
  assign w_en = rdy & ~rst;
  assign w_ram_wr = w_en & ~w_io & r_nw_in;
  assign w_tx_full = r_cnt == (PW+1)'(TX_DEPTH);
  assign tx_valid = r_cnt != '0;
  assign tx_data = r_tx[r_tail];
  assign w_pop = w_en & tx_valid & tx_ready;
  assign w_push = w_en & w_io & r_nw_in & (w_sel == 3'd0) & (~w_tx_full | w_pop);
  assign w_halt_wr = w_en & w_io & r_nw_in & (w_sel == 3'd4);
  assign w_rx_rd = w_en & w_io & ~r_nw_in & (w_sel == 3'd0);
  assign rx_ready = ~rst & rdy & ~r_rx_full;
  assign w_rx_cap = rx_valid & rx_ready;
  // read mux: RAM byte, RX holding byte, or status word
  always_comb begin
    w_rdata = ~w_io ? r_mem[w_idx] :
              (w_sel == 3'd0) ? (r_rx_full ? r_rx : 8'h00) :
              (w_sel == 3'd4) ? {6'b0, r_rx_full, w_tx_full} : 8'h00;
  end
  // RAM write port; contents survive reset
  always_ff @(posedge clk) begin
    if (w_ram_wr) r_mem[w_idx] <= wdata_in;
  end
  // registered read data, one cycle after the address
  always_ff @(posedge clk) begin
    if (rst) rdata_out <= 8'h00;
    else if (rdy) rdata_out <= w_rdata;
  end
  // TX FIFO storage
  always_ff @(posedge clk) begin
    if (w_push) r_tx[r_head] <= wdata_in;
  end
  // TX FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head <= '0;
      r_tail <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_head <= r_head + 1'b1;
      if (w_pop) r_tail <= r_tail + 1'b1;
      r_cnt <= r_cnt + (PW+1)'(w_push) - (PW+1)'(w_pop);
    end
  end
  // RX holding register; a same-cycle capture wins over the clearing read
  always_ff @(posedge clk) begin
    if (rst) r_rx_full <= 1'b0;
    else if (w_rx_cap) begin
      r_rx <= rx_data;
      r_rx_full <= 1'b1;
    end else if (w_rx_rd) r_rx_full <= 1'b0;
  end
  // sticky halt flag
  always_ff @(posedge clk) begin
    if (rst) halt <= 1'b0;
    else if (w_halt_wr) halt <= 1'b1;
  end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed stimulus with queued expectations checked by a monitor
module tb_mem_responder;
  logic clk = 0, rst = 1, rdy = 1, r_nw_in = 0, tx_ready = 0, rx_valid = 0;
  logic [31:0] addr_in = 0;
  logic [7:0] wdata_in = 0, rx_data = 0, rdata_out, tx_data;
  logic tx_valid, rx_ready, halt;
  int checks = 0, errors = 0;
  logic [7:0] rq[$], txq[$];
  logic chk = 0, chk_d = 0;
  always #5 clk = ~clk;
  mem_responder dut (
    .clk(clk), .rst(rst), .rdy(rdy), .addr_in(addr_in), .r_nw_in(r_nw_in),
    .wdata_in(wdata_in), .rdata_out(rdata_out), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready), .halt(halt)
  );
  task automatic cmp(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0h want %0h", n, a, e);
    end
  endtask
  task automatic cyc(input logic [31:0] a, input logic nw, input logic [7:0] wd, input logic c, input logic [7:0] e);
    @(posedge clk);
    #1;
    addr_in = a;
    r_nw_in = nw;
    wdata_in = wd;
    chk = c;
    if (c) rq.push_back(e);
  endtask
  always @(posedge clk) chk_d <= chk;
  always @(negedge clk) begin
    if (chk_d) begin
      if (rq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rdata unexpected got %0h want none", rdata_out);
      end else cmp("rdata", rdata_out, rq.pop_front());
    end
    if (tx_valid && tx_ready) begin
      if (txq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL tx_data unexpected got %0h want none", tx_data);
      end else cmp("tx_data", tx_data, txq.pop_front());
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "timeout");
  end
  initial begin
    repeat (3) cyc(0, 0, 0, 0, 0);
    cmp("rst_rdata", rdata_out, 0);
    cmp("rst_tx_valid", tx_valid, 0);
    cmp("rst_halt", halt, 0);
    cmp("rst_rx_ready", rx_ready, 0);
    rst = 0;
    #1;
    cmp("rx_ready_idle", rx_ready, 1);
    cyc(32'h10, 1, 8'hA5, 0, 0);
    cyc(32'h10, 0, 0, 1, 8'hA5);
    for (int i = 0; i < 4; i++) cyc(32'h100 + i, 1, 8'(8'h11 * (i + 1)), 0, 0);
    for (int i = 0; i < 4; i++) cyc(32'h100 + i, 0, 0, 1, 8'(8'h11 * (i + 1)));
    for (int i = 0; i < 17; i++) begin
      cyc(32'h30000, 1, 8'(i), 0, 0);
      if (i < 16) txq.push_back(8'(i));
    end
    cyc(32'h30004, 0, 0, 1, 8'h01);
    cyc(0, 0, 0, 0, 0);
    tx_ready = 1;
    repeat (20) cyc(0, 0, 0, 0, 0);
    cmp("tx_drained_valid", tx_valid, 0);
    cmp("tx_drained_q", txq.size(), 0);
    tx_ready = 0;
    for (int i = 0; i < 17; i++) txq.push_back(8'(8'h20 + i));
    for (int i = 0; i < 16; i++) cyc(32'h30000, 1, 8'(8'h20 + i), 0, 0);
    cyc(32'h30000, 1, 8'h30, 0, 0);
    tx_ready = 1;
    repeat (20) cyc(0, 0, 0, 0, 0);
    cmp("tx_full_pushpop_q", txq.size(), 0);
    cmp("tx_full_pushpop_valid", tx_valid, 0);
    tx_ready = 0;
    cyc(0, 0, 0, 0, 0);
    rx_valid = 1;
    rx_data = 8'h5A;
    cyc(0, 0, 0, 0, 0);
    rx_valid = 0;
    cmp("rx_ready_full", rx_ready, 0);
    cyc(32'h30004, 0, 0, 1, 8'h02);
    cyc(32'h30000, 0, 0, 1, 8'h5A);
    cyc(32'h30000, 0, 0, 1, 8'h00);
    cyc(32'h30000, 0, 0, 1, 8'h00);
    rx_valid = 1;
    rx_data = 8'h77;
    cyc(32'h30000, 0, 0, 1, 8'h77);
    rx_valid = 0;
    cyc(32'h20, 1, 8'h55, 0, 0);
    cyc(32'h30004, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cmp("halt_set", halt, 1);
    cyc(32'h10, 0, 0, 1, 8'hA5);
    cyc(32'h100, 0, 0, 1, 8'hA5);
    rdy = 0;
    cyc(32'h20, 1, 8'hEE, 0, 0);
    #1;
    cmp("rx_ready_rdy0", rx_ready, 0);
    cyc(32'h20, 0, 0, 1, 8'h55);
    rdy = 1;
    cyc(32'h30000, 1, 8'h99, 0, 0);
    cyc(32'h30000, 1, 8'h98, 0, 0);
    cyc(0, 0, 0, 0, 0);
    rx_valid = 1;
    rx_data = 8'h42;
    cyc(0, 0, 0, 0, 0);
    rx_valid = 0;
    cmp("pre_rst_tx_valid", tx_valid, 1);
    rst = 1;
    cyc(0, 0, 0, 0, 0);
    cmp("mid_rst_halt", halt, 0);
    cmp("mid_rst_tx_valid", tx_valid, 0);
    cmp("mid_rst_rdata", rdata_out, 0);
    rst = 0;
    cyc(32'h30004, 0, 0, 1, 8'h00);
    cyc(32'h30000, 0, 0, 1, 8'h00);
    cyc(32'h10, 0, 0, 1, 8'hA5);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cmp("rq_empty", rq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
